// File: rtl/msk_feed_pkg.sv
// Shared types and widths for the masked GF(16) multiplier feeder.
// Default share/randomness geometry: D=2, REF_LAT=1, REF_NRND=1, DOM_NRND=1.
package msk_feed_pkg;

  localparam int D_DEF        = 2;
  localparam int REF_LAT_DEF  = 1;
  localparam int REF_NRND_DEF = 1;
  localparam int DOM_NRND_DEF = 1;

  localparam int W_SH     = 4 * D_DEF;
  localparam int W_RREF   = 4 * REF_NRND_DEF;
  localparam int W_RMUL   = 4 * DOM_NRND_DEF;
  localparam int W_STARVE = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hr_state_t;

  // Saturating increment for the 8-bit starvation counter.
  function automatic logic [W_STARVE-1:0] sat_inc8(input logic [W_STARVE-1:0] v);
    return (v == '1) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/msk_delay_line.sv
// Fixed-latency register chain with synchronous reset; DEPTH cycles from i_d to o_q.
module msk_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [DEPTH];

  // NOTE: every stage is reset: this is a latency pipe for shares and valid
  // bits, not a storage array, and a stale stage must never outlive a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/msk_g16mul_feeder.sv
// Issue stage for the pipelined masked HPC1 GF(16) multiplier: aligns operands and randomness
// to the multiplier's refresh latency. Define MSKFEED_ZERO_IDLE_EN to zero idle share outputs.
module msk_g16mul_feeder
  import msk_feed_pkg::*;
#(
  parameter int D        = D_DEF,
  parameter int REF_LAT  = REF_LAT_DEF,
  parameter int REF_NRND = REF_NRND_DEF,
  parameter int DOM_NRND = DOM_NRND_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [4*D-1:0]                     in_a,
  input  logic [4*D-1:0]                     in_b,
  input  logic                               rnd_valid,
  output logic                               rnd_ready,
  input  logic [4*REF_NRND+4*DOM_NRND-1:0]   rnd_in,
  output logic [4*D-1:0]                     mul_ina,
  output logic [4*D-1:0]                     mul_inb,
  output logic [4*REF_NRND-1:0]              mul_rref,
  output logic [4*DOM_NRND-1:0]              mul_rmul,
  output logic                               prod_valid,
  output logic [W_STARVE-1:0]                starve_cnt
);

  localparam int SH     = 4 * D;
  localparam int RR     = 4 * REF_NRND;
  localparam int RM     = 4 * DOM_NRND;
  localparam int W_LINE = SH + RM;

  hr_state_t           r_state;
  logic [SH-1:0]       r_hr_a;
  logic [SH-1:0]       r_hr_b;
  logic [W_STARVE-1:0] r_starve;

  logic                w_accept;
  logic                w_issue;
  logic [RR-1:0]       w_rnd_ref;
  logic [RM-1:0]       w_rnd_mul;
  logic [SH-1:0]       w_idle_a;
  logic [SH-1:0]       w_idle_b;
  logic [RR-1:0]       w_idle_rref;
  logic [RM-1:0]       w_idle_rmul;
  logic [W_LINE-1:0]   w_line_in;
  logic [W_LINE-1:0]   w_line_out;

  assign w_rnd_ref = rnd_in[RR-1:0];
  assign w_rnd_mul = rnd_in[RR +: RM];

  // Ready depends only on the holding state, never on this cycle's issue.
  assign in_ready  = !rst && (r_state == EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_issue   = !rst && (r_state == FULL) && rnd_valid;
  assign rnd_ready = w_issue;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_hr_a  <= '0;
      r_hr_b  <= '0;
    end else begin
      case (r_state)
        EMPTY: if (w_accept) begin
          r_state <= FULL;
          r_hr_a  <= in_a;
          r_hr_b  <= in_b;
        end
        FULL: if (w_issue) r_state <= EMPTY;
        default: r_state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if ((r_state == FULL) && !rnd_valid) begin
      r_starve <= sat_inc8(r_starve);
    end
  end

  assign starve_cnt = r_starve;

`ifndef MSKFEED_ZERO_IDLE_EN
  logic [SH-1:0] r_last_a;
  logic [SH-1:0] r_last_b;
  logic [RR-1:0] r_last_rref;
  logic [RM-1:0] r_last_rmul;

  // Last issued values, replayed on idle cycles so the outputs hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_a    <= '0;
      r_last_b    <= '0;
      r_last_rref <= '0;
      r_last_rmul <= '0;
    end else if (w_issue) begin
      r_last_a    <= r_hr_a;
      r_last_b    <= r_hr_b;
      r_last_rref <= w_rnd_ref;
      r_last_rmul <= w_rnd_mul;
    end
  end
`endif

  // NOTE: every output of this block gets a default first, so no path through
  // it can leave a value unassigned and infer a latch.
  always_comb begin
    w_idle_a    = '0;
    w_idle_b    = '0;
    w_idle_rref = '0;
    w_idle_rmul = '0;
`ifndef MSKFEED_ZERO_IDLE_EN
    w_idle_a    = r_last_a;
    w_idle_b    = r_last_b;
    w_idle_rref = r_last_rref;
    w_idle_rmul = r_last_rmul;
`endif
  end

  assign mul_inb  = w_issue ? r_hr_b    : w_idle_b;
  assign mul_rref = w_issue ? w_rnd_ref : w_idle_rref;

  // In zero-idle builds the idle input is 0, so each tail slot shows for one cycle only.
  assign w_line_in = w_issue ? {r_hr_a, w_rnd_mul} : {w_idle_a, w_idle_rmul};

  msk_delay_line #(
    .W     (W_LINE),
    .DEPTH (1 + REF_LAT)
  ) u_a_line (
    .clk (clk),
    .rst (rst),
    .i_d (w_line_in),
    .o_q (w_line_out)
  );

  assign mul_ina  = w_line_out[W_LINE-1 -: SH];
  assign mul_rmul = w_line_out[RM-1:0];

  msk_delay_line #(
    .W     (1),
    .DEPTH (2 + REF_LAT)
  ) u_valid_pipe (
    .clk (clk),
    .rst (rst),
    .i_d (w_issue),
    .o_q (prod_valid)
  );

endmodule

// File: tb/tb_msk_g16mul_feeder.sv
// Self-checking bench for msk_g16mul_feeder: transaction-level model with per-cycle compare,
// directed literal checks, randomized traffic and a GF(16) recombination sweep.
module tb_msk_g16mul_feeder;

  localparam int NCYC = 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       rnd_valid = 1'b0;
  logic       rnd_ready;
  logic [7:0] rnd_in = '0;
  logic [7:0] mul_ina;
  logic [7:0] mul_inb;
  logic [3:0] mul_rref;
  logic [3:0] mul_rmul;
  logic       prod_valid;
  logic [7:0] starve_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  msk_g16mul_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .rnd_in     (rnd_in),
    .mul_ina    (mul_ina),
    .mul_inb    (mul_inb),
    .mul_rref   (mul_rref),
    .mul_rmul   (mul_rmul),
    .prod_valid (prod_valid),
    .starve_cnt (starve_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit         m_have_rst = 0;
  bit         m_full = 0;
  logic [7:0] m_a, m_b;
  int         m_rr = -1;
  int         m_last = -1;
  int         m_starve = 0;
  bit         iss [NCYC];
  logic [7:0] ia  [NCYC];
  logic [7:0] ib  [NCYC];
  logic [3:0] irr [NCYC];
  logic [3:0] irm [NCYC];

  always @(negedge clk) begin : cmp_proc
    bit         e_issue;
    bit         e_prod;
    logic [7:0] e_inb, e_ina;
    logic [3:0] e_rref, e_rmul;
    int         src;
    if (cyc >= NCYC - 1) begin
      $display("FAIL model_capacity: got %0d cycles, limit %0d", cyc, NCYC);
      $fatal(1, "cycle capacity exceeded");
    end
    e_issue = !rst && m_full && rnd_valid;
    if (m_have_rst) begin
      src = -1;
`ifdef MSKFEED_ZERO_IDLE_EN
      if (cyc - 2 > m_rr) if (iss[cyc-2]) src = cyc - 2;
      e_inb  = e_issue ? m_b : 8'h00;
      e_rref = e_issue ? rnd_in[3:0] : 4'h0;
`else
      for (int i = cyc - 2; i > m_rr; i--) if (iss[i]) begin src = i; break; end
      e_inb  = e_issue ? m_b : ((m_last >= 0) ? ib[m_last] : 8'h00);
      e_rref = e_issue ? rnd_in[3:0] : ((m_last >= 0) ? irr[m_last] : 4'h0);
`endif
      e_ina  = (src >= 0) ? ia[src]  : 8'h00;
      e_rmul = (src >= 0) ? irm[src] : 4'h0;
      e_prod = 0;
      if (cyc - 3 > m_rr) e_prod = iss[cyc-3];
      check("in_ready",   in_ready,   !rst && !m_full);
      check("rnd_ready",  rnd_ready,  e_issue);
      check("mul_inb",    mul_inb,    e_inb);
      check("mul_rref",   mul_rref,   e_rref);
      check("mul_ina",    mul_ina,    e_ina);
      check("mul_rmul",   mul_rmul,   e_rmul);
      check("prod_valid", prod_valid, e_prod);
      check("starve_cnt", starve_cnt, m_starve);
    end
    if (rst) begin
      m_have_rst = 1;
      m_full     = 0;
      m_rr       = cyc;
      m_last     = -1;
      m_starve   = 0;
    end else if (m_full) begin
      if (rnd_valid) begin
        iss[cyc] = 1;
        ia[cyc]  = m_a;
        ib[cyc]  = m_b;
        irr[cyc] = rnd_in[3:0];
        irm[cyc] = rnd_in[7:4];
        m_last   = cyc;
        m_full   = 0;
      end else if (m_starve < 255) begin
        m_starve++;
      end
    end else if (in_valid) begin
      m_full = 1;
      m_a    = in_a;
      m_b    = in_b;
    end
    cyc++;
  end

  // ---------------- GF(16) helpers (x^4+x+1) ----------------
  function automatic logic [3:0] gf_shift(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] aa;
    logic [3:0] p;
    aa = {1'b0, a};
    p  = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= aa[3:0];
      aa = aa << 1;
      if (aa[4]) aa ^= 5'b10011;
    end
    return p;
  endfunction

  function automatic logic [3:0] gf_log(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] exp_t [15];
    int         log_t [16];
    logic [4:0] e;
    e = 5'd1;
    for (int k = 0; k < 15; k++) begin
      exp_t[k] = e[3:0];
      log_t[e[3:0]] = k;
      e = e << 1;
      if (e[4]) e ^= 5'b10011;
    end
    if (a == 0 || b == 0) return 4'h0;
    return exp_t[(log_t[a] + log_t[b]) % 15];
  endfunction

  function automatic logic [7:0] share4(input logic [3:0] v);
    logic [7:0] s;
    logic       r;
    for (int i = 0; i < 4; i++) begin
      r = 1'($urandom % 2);
      s[2*i]   = r;
      s[2*i+1] = v[i] ^ r;
    end
    return s;
  endfunction

  function automatic logic [3:0] unmask(input logic [7:0] s);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = s[2*i] ^ s[2*i+1];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_acc, n_rnd, n_prod, last_p;
    logic [7:0] cap_a, cap_b;

    tick();
    tick();
    rst = 1'b0;
    settle();
    check("t1_ready_after_rst", in_ready, 1'b1);

    // Test 1: single op
    tick();
    in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h3C; rnd_valid = 1'b1; rnd_in = 8'h5A;
    tick();
    in_valid = 1'b0;
    settle();
    check("t1_issue_rnd_ready", rnd_ready, 1'b1);
    check("t1_issue_inb", mul_inb, 8'h3C);
    check("t1_issue_rref", mul_rref, 4'hA);
    tick(); settle();
    check("t1_no_second_issue", rnd_ready, 1'b0);
    check("t1_prod_early", prod_valid, 1'b0);
    tick(); settle();
    check("t1_ina", mul_ina, 8'hA5);
    check("t1_rmul", mul_rmul, 4'h5);
    check("t1_prod_t3", prod_valid, 1'b0);
    tick(); settle();
    check("t1_prod_t4", prod_valid, 1'b1);
    tick(); settle();
    check("t1_prod_t5", prod_valid, 1'b0);

    // Test 2: starvation for 10 cycles
    rnd_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("t2_in_ready_low", in_ready, 1'b0);
      check("t2_no_issue", rnd_ready, 1'b0);
      tick();
    end
    rnd_valid = 1'b1; rnd_in = 8'($urandom);
    settle();
    check("t2_starve_10", starve_cnt, 8'd10);
    check("t2_issue_on_rise", rnd_ready, 1'b1);
    tick();
    rnd_valid = 1'b0;

    // Test 3: saturation
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
    tick();
    in_valid = 1'b0;
    repeat (300) tick();
    settle();
    check("t3_starve_sat", starve_cnt, 8'd255);
    rnd_valid = 1'b1;
    tick();
    rnd_valid = 1'b0;
    repeat (5) tick();

    // Test 4: stream of 8 ops
    n_acc = 0; n_rnd = 0; n_prod = 0; last_p = -1;
    rnd_valid = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); rnd_in = 8'($urandom);
      settle();
      if (in_valid && in_ready) n_acc++;
      if (rnd_ready) n_rnd++;
      if (prod_valid) begin
        if (last_p >= 0) check("t4_prod_gap", k - last_p, 2);
        last_p = k;
        n_prod++;
      end
      tick();
      if (n_acc == 8) in_valid = 1'b0;
    end
    check("t4_prod_count", n_prod, 8);
    check("t4_rnd_count", n_rnd, 8);

    // Test 5: reset one cycle after issue
    rnd_valid = 1'b0; in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
    tick();
    in_valid = 1'b0; rnd_valid = 1'b1; rnd_in = 8'($urandom);
    tick();
    rnd_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("t5_ina_zero", mul_ina, 8'h00);
    check("t5_inb_zero", mul_inb, 8'h00);
    check("t5_rref_zero", mul_rref, 4'h0);
    check("t5_rmul_zero", mul_rmul, 4'h0);
    check("t5_prod_zero", prod_valid, 1'b0);
    check("t5_starve_zero", starve_cnt, 8'd0);
    check("t5_rnd_ready_zero", rnd_ready, 1'b0);
    check("t5_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick(); settle();
      check("t5_prod_stays_zero", prod_valid, 1'b0);
    end

    // Random traffic with occasional resets
    for (int k = 0; k < 800; k++) begin
      tick();
      in_valid  = 1'($urandom % 2);
      rnd_valid = (($urandom % 4) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      rnd_in    = 8'($urandom);
      rst       = (($urandom % 97) == 0);
    end
    tick();
    rst = 1'b0; in_valid = 1'b0; rnd_valid = 1'b1;
    repeat (4) tick();

    // Test 6: recombination over all operand pairs
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        in_valid = 1'b1; rnd_valid = 1'b1; rnd_in = 8'($urandom);
        in_a = share4(4'(a)); in_b = share4(4'(b));
        tick();
        in_valid = 1'b0;
        settle();
        cap_b = mul_inb;
        tick();
        tick(); settle();
        cap_a = mul_ina;
        tick(); settle();
        check("t6_prod_valid", prod_valid, 1'b1);
        check("t6_gf_product", gf_shift(unmask(cap_a), unmask(cap_b)), gf_log(4'(a), 4'(b)));
        tick();
      end
    end

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
